// File: rtl/muldiv_sequencer.sv
// Sequential mult/multu/div/divu unit with architectural HI/LO registers.
// Latency: 33 cycles from accepted start to done; start is ignored while busy (no queuing).
module muldiv_sequencer #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_div;
    logic          neg_res;
    logic          neg_rem;
    logic          div0;
    logic [31:0]   a_cap;
    logic [31:0]   opnd;   // multiplicand for mult, divisor for div
    logic [31:0]   acc;    // product high half / partial remainder
    logic [31:0]   mq;     // multiplier shifting out / quotient shifting in

    logic          sgn, a_neg, b_neg;
    logic [31:0]   a_mag, b_mag;
    logic [32:0]   add_sum;
    logic [32:0]   shl;
    logic          borrow;
    logic [31:0]   diff;
    logic [63:0]   prod_fix;
    logic [31:0]   q_fix, r_fix;

    always_comb begin
        sgn      = ~op[0];
        a_neg    = sgn & a[31];
        b_neg    = sgn & b[31];
        a_mag    = a_neg ? (~a + 32'd1) : a;
        b_mag    = b_neg ? (~b + 32'd1) : b;
        add_sum  = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : 33'd0);
        shl      = {acc, mq[31]};
        borrow   = shl < {1'b0, opnd};
        diff     = shl[31:0] - opnd;
        prod_fix = neg_res ? (~{acc, mq} + 64'd1) : {acc, mq};
        q_fix    = neg_res ? (~mq + 32'd1) : mq;
        r_fix    = neg_rem ? (~acc + 32'd1) : acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            a_cap   <= '0;
            opnd    <= '0;
            acc     <= '0;
            mq      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mthi_we) hi <= wdata;
                    if (mtlo_we) lo <= wdata;
                    if (start) begin
                        is_div  <= op[1];
                        a_cap   <= a;
                        div0    <= op[1] & (b == 32'd0);
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        opnd    <= op[1] ? b_mag : a_mag;
                        mq      <= op[1] ? a_mag : b_mag;
                        acc     <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        acc <= borrow ? shl[31:0] : diff;
                        mq  <= {mq[30:0], ~borrow};
                    end else begin
                        acc <= add_sum[32:1];
                        mq  <= {add_sum[0], mq[31:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_FIX;
                end
                S_FIX: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    cnt   <= '0;
                    state <= S_IDLE;
                    if (!is_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (div0) begin
                        // Divide by zero ignores whatever the datapath accumulated.
                        lo <= 32'hFFFF_FFFF;
                        hi <= a_cap;
                    end else begin
                        lo <= q_fix;
                        hi <= r_fix;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a cycle-level arithmetic model checked every cycle,
// plus literal expected results for each operation.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, mthi_we, mtlo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    muldiv_sequencer #(.ITER(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Architectural result of one operation, from plain arithmetic.
    task automatic expect_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] rh, output logic [31:0] rl);
        longint          sp;
        longint unsigned up;
        int              sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            2'b00: begin sp = longint'(sx) * longint'(sy); {rh, rl} = sp; end
            2'b01: begin up = {32'd0, x} * {32'd0, y}; {rh, rl} = up; end
            2'b10: begin
                if (y == 32'd0) begin rl = 32'hFFFF_FFFF; rh = x; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin rl = 32'h8000_0000; rh = 32'd0; end
                else begin rl = sx / sy; rh = sx % sy; end
            end
            default: begin
                if (y == 32'd0) begin rl = 32'hFFFF_FFFF; rh = x; end
                else begin rl = x / y; rh = x % y; end
            end
        endcase
    endtask

    bit          m_busy, m_done;
    logic [31:0] m_hi, m_lo, r_hi, r_lo;
    int          m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_hi = r_hi; m_lo = r_lo;
                end
            end else begin
                if (mthi_we) m_hi = wdata;
                if (mtlo_we) m_lo = wdata;
                if (start) begin
                    expect_result(op, a, b, r_hi, r_lo);
                    m_busy = 1'b1;
                    m_left = 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model busy", {31'd0, busy}, {31'd0, m_busy});
            chk("model done", {31'd0, done}, {31'd0, m_done});
            chk("model hi", hi, m_hi);
            chk("model lo", lo, m_lo);
        end
    end

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input bit inj, input string name);
        int k;
        start = 1'b1; op = o; a = x; b = y;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                chk({name, " busy after start"}, {31'd0, busy}, 32'd1);
                start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
                op = ~o; a = 32'h5A5A_1234; b = 32'h0000_0003;
            end
            if (inj) begin
                case (k)
                    10: begin start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3; end
                    11: start = 1'b0;
                    12: begin mthi_we = 1'b1; wdata = 32'h0000_AAAA; end
                    13: mthi_we = 1'b0;
                    default: ;
                endcase
            end
        end while (!done && k < 40);
        chk({name, " latency"}, k, 34);
        chk({name, " hi"}, hi, exp_hi);
        chk({name, " lo"}, lo, exp_lo);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        mthi_we = 1'b0; mtlo_we = 1'b0;
        chk("mthi idle", hi, 32'h0000_1234);
        chk("mtlo idle", lo, 32'h0000_1234);

        // Back-to-back runs also start each op in the done cycle of the previous one.
        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu max");
        run(2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, "mult -3*5");
        run(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div -7/2");
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div ovf");
        run(2'b11, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, 1'b0, "divu by 0");
        run(2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, "divu 100/7");
        run(2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, "div by 0");
        run(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult min*min");
        run(2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div 7/-2");

        mthi_we = 1'b1; wdata = 32'h0000_DEAD;
        run(2'b01, 32'd2, 32'd3, 32'h0000_0000, 32'h0000_0006, 1'b0, "multu with mthi");

        run(2'b01, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 1'b1, "multu ignore");

        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        run(2'b01, 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A, 1'b0, "multu after reset");

        mtlo_we = 1'b1; wdata = 32'h0000_0055;
        @(negedge clk);
        mtlo_we = 1'b0;
        chk("mtlo only lo", lo, 32'h0000_0055);
        chk("mtlo only hi", hi, 32'h0000_0000);
        @(negedge clk);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
